filter_coe_ctrl: RTL and testbench

- Configuration controller for the 2-D convolution filter's coefficient matrix.
- Holds two coefficient banks: a shadow bank written by software over a simple register port, and an active bank driving the filter datapath.
- On software commit, swaps banks at the next video start-of-frame, so a frame is never filtered with mixed coefficients.
- After the swap, copies the new active bank back into the shadow bank, so software can make incremental edits.

---
 rtl/filter_pkg.sv | 22 ++
 rtl/filter_coe_ctrl_if.sv | 27 ++
 rtl/filter_coe_bank.sv | 44 ++++
 rtl/filter_coe_ctrl.sv | 118 +++++++++++
 tb/tb_filter_coe_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the 2-D convolution filter coefficient path:
// default sizes, controller state encoding and the identity kernel.
package filter_pkg;

    localparam int DEF_CORE_DIM  = 5;
    localparam int DEF_COE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SWAP  = 2'd2,
        COPY  = 2'd3
    } state_t;

    // Centre tap at +1.0 (largest positive Q1.x value), every other tap zero.
    function automatic logic [31:0] ident_coe(int k, int dim, int w);
        if (k == (dim * dim) / 2)
            return (32'd1 << (w - 1)) - 32'd1;
        return 32'd0;
    endfunction

endpackage

// File: rtl/filter_coe_ctrl_if.sv
// Software register port for the coefficient controller.
// The bus master writes coefficients and requests commits; the controller reports status.
interface filter_coe_ctrl_if
    import filter_pkg::*;
#(
    parameter int COE_WIDTH = DEF_COE_WIDTH
);

    logic                 cfg_wr_en;
    logic [7:0]           cfg_addr;
    logic [COE_WIDTH-1:0] cfg_wdata;
    logic                 cfg_commit;
    logic                 cfg_busy;
    logic                 cfg_err;
    logic                 commit_done;

    modport master (
        output cfg_wr_en, cfg_addr, cfg_wdata, cfg_commit,
        input  cfg_busy, cfg_err, commit_done
    );

    modport slave (
        input  cfg_wr_en, cfg_addr, cfg_wdata, cfg_commit,
        output cfg_busy, cfg_err, commit_done
    );

endinterface

// File: rtl/filter_coe_bank.sv
// Two-bank coefficient register file. Software writes and the copy-back both
// target the bank not selected by sel; rd_flat presents a whole bank in parallel.
module filter_coe_bank
    import filter_pkg::*;
#(
    parameter int FILTER_CORE_DIM = DEF_CORE_DIM,
    parameter int COE_WIDTH       = DEF_COE_WIDTH,
    localparam int N              = FILTER_CORE_DIM * FILTER_CORE_DIM,
    localparam int IW             = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_addr,
    input  logic [COE_WIDTH-1:0]   wr_data,
    input  logic                   cp_en,
    input  logic [IW-1:0]          cp_idx,
    input  logic                   rd_sel,
    output logic [N*COE_WIDTH-1:0] rd_flat
);

    logic [COE_WIDTH-1:0] mem [2][N];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                mem[0][k] <= COE_WIDTH'(ident_coe(k, FILTER_CORE_DIM, COE_WIDTH));
                mem[1][k] <= COE_WIDTH'(ident_coe(k, FILTER_CORE_DIM, COE_WIDTH));
            end
        end else if (wr_en) begin
            mem[~sel][wr_addr] <= wr_data;
        end else if (cp_en) begin
            mem[~sel][cp_idx] <= mem[sel][cp_idx];
        end
    end

    always_comb begin
        rd_flat = '0;
        for (int k = 0; k < N; k++)
            rd_flat[k*COE_WIDTH +: COE_WIDTH] = mem[rd_sel][k];
    end

endmodule

// File: rtl/filter_coe_ctrl.sv
// Coefficient bank controller: software edits the shadow bank, a commit swaps
// banks on the next start-of-frame, then the new active bank is copied back.
module filter_coe_ctrl
    import filter_pkg::*;
#(
    parameter int FILTER_CORE_DIM = DEF_CORE_DIM,
    parameter int COE_WIDTH       = DEF_COE_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    filter_coe_ctrl_if.slave         cfg,
    input  logic                     vid_sof,
    output logic [FILTER_CORE_DIM*FILTER_CORE_DIM*COE_WIDTH-1:0] coe_flat,
    output logic                     active_bank,
    output logic [15:0]              frame_cnt
);

    localparam int N  = FILTER_CORE_DIM * FILTER_CORE_DIM;
    localparam int IW = $clog2(N);

    function automatic logic [N*COE_WIDTH-1:0] ident_flat();
        logic [N*COE_WIDTH-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++)
            f[k*COE_WIDTH +: COE_WIDTH] =
                COE_WIDTH'(ident_coe(k, FILTER_CORE_DIM, COE_WIDTH));
        return f;
    endfunction

    localparam logic [N*COE_WIDTH-1:0] IDENT = ident_flat();

    state_t                 state;
    logic [IW-1:0]          copy_idx;
    logic                   busy;
    logic                   err;
    logic                   done;
    logic                   addr_ok;
    logic                   bank_wr;
    logic                   bank_cp;
    logic                   req;
    logic [N*COE_WIDTH-1:0] shadow_flat;

    assign addr_ok = cfg.cfg_addr < 8'(N);
    assign bank_wr = (state == IDLE) && cfg.cfg_wr_en && addr_ok;
    assign bank_cp = (state == COPY);
    assign req     = cfg.cfg_wr_en || cfg.cfg_commit;

    assign cfg.cfg_busy    = busy;
    assign cfg.cfg_err     = err;
    assign cfg.commit_done = done;

    filter_coe_bank #(
        .FILTER_CORE_DIM (FILTER_CORE_DIM),
        .COE_WIDTH       (COE_WIDTH)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .sel     (active_bank),
        .wr_en   (bank_wr),
        .wr_addr (cfg.cfg_addr[IW-1:0]),
        .wr_data (cfg.cfg_wdata),
        .cp_en   (bank_cp),
        .cp_idx  (copy_idx),
        .rd_sel  (~active_bank),
        .rd_flat (shadow_flat)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            copy_idx    <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
            active_bank <= 1'b0;
            frame_cnt   <= '0;
            coe_flat    <= IDENT;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            if (vid_sof)
                frame_cnt <= frame_cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    err <= cfg.cfg_wr_en && !addr_ok;
                    // An SOF coincident with the commit is deliberately not taken.
                    if (cfg.cfg_commit) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    err <= req;
                    if (vid_sof)
                        state <= SWAP;
                end
                SWAP: begin
                    err         <= req;
                    active_bank <= ~active_bank;
                    coe_flat    <= shadow_flat;
                    copy_idx    <= '0;
                    state       <= COPY;
                end
                COPY: begin
                    err      <= req;
                    copy_idx <= copy_idx + 1'b1;
                    if (copy_idx == IW'(N - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_coe_ctrl.sv
// Randomised self-checking bench for filter_coe_ctrl against a bank-level
// model of shadow/active coefficient sets and a frame counter.
module tb_filter_coe_ctrl;

    localparam int DIM = 5;
    localparam int W   = 16;
    localparam int N   = DIM * DIM;

    logic             clk = 1'b0;
    logic             reset;
    logic             vid_sof;
    logic [N*W-1:0]   coe_flat;
    logic             active_bank;
    logic [15:0]      frame_cnt;

    filter_coe_ctrl_if #(.COE_WIDTH(W)) cfg ();

    filter_coe_ctrl #(
        .FILTER_CORE_DIM (DIM),
        .COE_WIDTH       (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg),
        .vid_sof     (vid_sof),
        .coe_flat    (coe_flat),
        .active_bank (active_bank),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_shadow [N];
    logic [W-1:0] m_active [N];
    logic         m_bank;
    logic         m_busy;
    logic [15:0]  m_frames;

    function automatic logic [N*W-1:0] exp_flat();
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++)
            f[k*W +: W] = m_active[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = (k == N / 2) ? 16'h7FFF : 16'h0000;
            m_active[k] = m_shadow[k];
        end
        m_bank = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset)
            m_frames = '0;
        else if (vid_sof)
            m_frames = m_frames + 16'd1;
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [W-1:0] data);
        cfg.cfg_wr_en = 1'b1;
        cfg.cfg_addr  = addr;
        cfg.cfg_wdata = data;
        tick();
        cfg.cfg_wr_en = 1'b0;
        if (!m_busy && addr < 8'(N))
            m_shadow[addr] = data;
    endtask

    task automatic do_commit();
        cfg.cfg_commit = 1'b1;
        tick();
        cfg.cfg_commit = 1'b0;
        m_busy = 1'b1;
        n_tests++;
        if (cfg.cfg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_busy: got %b want 1", cfg.cfg_busy);
        end
    endtask

    task automatic run_swap();
        vid_sof = 1'b1;
        tick();
        vid_sof = 1'b0;
        n_tests++;
        if (coe_flat !== exp_flat() || active_bank !== m_bank) begin
            n_fail++;
            $display("FAIL swap_early: coe %h bank %b want coe %h bank %b",
                     coe_flat, active_bank, exp_flat(), m_bank);
        end
        tick();
        m_bank = ~m_bank;
        for (int k = 0; k < N; k++)
            m_active[k] = m_shadow[k];
        n_tests++;
        if (coe_flat !== exp_flat() || active_bank !== m_bank) begin
            n_fail++;
            $display("FAIL swap_load: coe %h bank %b want coe %h bank %b",
                     coe_flat, active_bank, exp_flat(), m_bank);
        end
        for (int i = 0; i < N; i++) begin
            tick();
            n_tests++;
            if (cfg.commit_done !== (i == N - 1) ||
                cfg.cfg_busy !== (i != N - 1)) begin
                n_fail++;
                $display("FAIL copy_cycle %0d: done %b busy %b", i,
                         cfg.commit_done, cfg.cfg_busy);
            end
        end
        m_busy = 1'b0;
        tick();
        n_tests++;
        if (cfg.commit_done !== 1'b0 || frame_cnt !== m_frames) begin
            n_fail++;
            $display("FAIL after_copy: done %b frame %0d want 0 %0d",
                     cfg.commit_done, frame_cnt, m_frames);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        model_reset();
        n_tests++;
        if (coe_flat !== exp_flat() || coe_flat[12*W +: W] !== 16'h7FFF ||
            active_bank !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_vals: coe %h bank %b frame %0d",
                     coe_flat, active_bank, frame_cnt);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (cfg.cfg_busy !== 1'b0 || cfg.cfg_err !== 1'b0 ||
            cfg.commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy %b err %b done %b",
                     cfg.cfg_busy, cfg.cfg_err, cfg.commit_done);
        end
    endtask

    task automatic test_commit();
        for (int a = 0; a < N; a++)
            cfg_write(8'(a), 16'h0100);
        do_commit();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (cfg.cfg_busy !== 1'b1 || active_bank !== m_bank) begin
                n_fail++;
                $display("FAIL armed_wait: busy %b bank %b", cfg.cfg_busy, active_bank);
            end
        end
        run_swap();
        n_tests++;
        if (active_bank !== 1'b1 || coe_flat !== {N{16'h0100}} ||
            cfg.cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_all_0100: coe %h bank %b busy %b",
                     coe_flat, active_bank, cfg.cfg_busy);
        end
    endtask

    task automatic test_bad_addr();
        logic [N*W-1:0] prev;
        prev = exp_flat();
        for (int r = 0; r < 4; r++) begin
            cfg_write(8'($urandom_range(N, 255)), 16'($urandom));
            n_tests++;
            if (cfg.cfg_err !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_addr_err: got %b want 1", cfg.cfg_err);
            end
            tick();
            n_tests++;
            if (cfg.cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_addr_pulse: got %b want 0", cfg.cfg_err);
            end
        end
        do_commit();
        tick();
        run_swap();
        n_tests++;
        if (coe_flat !== prev) begin
            n_fail++;
            $display("FAIL bad_addr_nowrite: coe %h want %h", coe_flat, prev);
        end
    endtask

    task automatic test_armed_write();
        logic [W-1:0] v;
        v = 16'($urandom);
        if (v == 16'h1234)
            v = 16'h4321;
        cfg_write(8'd3, v);
        n_tests++;
        if (cfg.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL good_write_err: got %b want 0", cfg.cfg_err);
        end
        do_commit();
        cfg_write(8'd3, 16'h1234);
        n_tests++;
        if (cfg.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_write_err: got %b want 1", cfg.cfg_err);
        end
        tick();
        run_swap();
        n_tests++;
        if (coe_flat[3*W +: W] !== v || coe_flat !== exp_flat()) begin
            n_fail++;
            $display("FAIL armed_write_kept: coe3 %h want %h", coe_flat[3*W +: W], v);
        end
    endtask

    task automatic test_sof_commit();
        cfg_write(8'($urandom_range(0, N - 1)), 16'($urandom));
        cfg.cfg_commit = 1'b1;
        vid_sof = 1'b1;
        tick();
        cfg.cfg_commit = 1'b0;
        vid_sof = 1'b0;
        m_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (cfg.cfg_busy !== 1'b1 || active_bank !== m_bank ||
            coe_flat !== exp_flat() || frame_cnt !== m_frames) begin
            n_fail++;
            $display("FAIL sof_commit_noswap: busy %b bank %b frame %0d want %0d",
                     cfg.cfg_busy, active_bank, frame_cnt, m_frames);
        end
        run_swap();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int nw;
            nw = $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 5) == 0)
                    cfg_write(8'($urandom_range(N, 255)), 16'($urandom));
                else
                    cfg_write(8'($urandom_range(0, N - 1)), 16'($urandom));
            end
            do_commit();
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) tick();
            run_swap();
            n_tests++;
            if (coe_flat !== exp_flat() || active_bank !== m_bank) begin
                n_fail++;
                $display("FAIL random_round %0d: coe %h want %h", r, coe_flat, exp_flat());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < N; a++)
            cfg_write(8'(a), 16'($urandom));
        do_commit();
        vid_sof = 1'b1;
        tick();
        vid_sof = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        tick();
        model_reset();
        n_tests++;
        if (coe_flat !== exp_flat() || active_bank !== 1'b0 ||
            cfg.cfg_busy !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_copy: coe %h bank %b busy %b frame %0d",
                     coe_flat, active_bank, cfg.cfg_busy, frame_cnt);
        end
        reset = 1'b1;
        do_commit();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_busy = 1'b0;
        vid_sof = 1'b1;
        tick();
        vid_sof = 1'b0;
        tick();
        tick();
        n_tests++;
        if (active_bank !== 1'b0 || cfg.cfg_busy !== 1'b0 || coe_flat !== exp_flat()) begin
            n_fail++;
            $display("FAIL reset_mid_armed: bank %b busy %b", active_bank, cfg.cfg_busy);
        end
        do_commit();
        run_swap();
        n_tests++;
        if (active_bank !== 1'b1 || coe_flat !== exp_flat()) begin
            n_fail++;
            $display("FAIL post_reset_shadow: coe %h want %h", coe_flat, exp_flat());
        end
    endtask

    task automatic test_frame_wrap();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        vid_sof = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        n_tests++;
        if (frame_cnt !== 16'hFFFF || frame_cnt !== m_frames) begin
            n_fail++;
            $display("FAIL frame_max: got %h want ffff", frame_cnt);
        end
        tick();
        vid_sof = 1'b0;
        n_tests++;
        if (frame_cnt !== 16'h0000 || frame_cnt !== m_frames ||
            active_bank !== 1'b0 || coe_flat !== exp_flat()) begin
            n_fail++;
            $display("FAIL frame_wrap: got %h want 0000 bank %b", frame_cnt, active_bank);
        end
    endtask

    initial begin
        reset          = 1'b0;
        vid_sof        = 1'b0;
        cfg.cfg_wr_en  = 1'b0;
        cfg.cfg_addr   = '0;
        cfg.cfg_wdata  = '0;
        cfg.cfg_commit = 1'b0;
        m_frames       = '0;
        model_reset();
        test_reset();
        test_commit();
        test_bad_addr();
        test_armed_write();
        test_sof_commit();
        test_random();
        test_reset_mid();
        test_frame_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
